// File: rtl/tx_accesscode_if.sv
// rtl/tx_accesscode_if.sv - link-controller / modulator bus for the access-code serializer
interface tx_accesscode_if;
  logic        p_1us;
  logic        tx_st_p;
  logic [63:0] tx_sync;
  logic        trailer_en;
  logic        tx_abort;
  logic        tx_bit;
  logic        tx_active;
  logic [6:0]  tx_bitcnt;
  logic        tx_ac_done_p;
  logic        tx_halftslotdly_endp;
  logic        tx_tslotdly_endp;

  modport master (
    output p_1us, tx_st_p, tx_sync, trailer_en, tx_abort,
    input  tx_bit, tx_active, tx_bitcnt, tx_ac_done_p,
           tx_halftslotdly_endp, tx_tslotdly_endp
  );

  modport slave (
    input  p_1us, tx_st_p, tx_sync, trailer_en, tx_abort,
    output tx_bit, tx_active, tx_bitcnt, tx_ac_done_p,
           tx_halftslotdly_endp, tx_tslotdly_endp
  );
endinterface

// File: rtl/tx_accesscode.sv
// rtl/tx_accesscode.sv - access-code serializer (preamble, LSB-first sync word, optional trailer) with TX slot timer
module tx_accesscode #(
  parameter logic [9:0] SLOT_TC = 10'd624,
  parameter logic [9:0] HALF_TC = 10'd312
) (
  input  logic           clk_6M,
  input  logic           rstz,
  tx_accesscode_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PRE, S_SYNC, S_TRL} state_t;

  state_t      r_state, w_nxt_state;
  logic [63:0] r_sr, w_nxt_sr;
  logic        r_trl, w_nxt_trl;
  logic        r_bit, w_nxt_bit;
  logic        r_active, w_nxt_active;
  logic [6:0]  r_bitcnt, w_nxt_bitcnt;
  logic        r_done, w_nxt_done;
  logic        r_slot_run;
  logic [9:0]  r_slot_cnt;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) & bus.tx_st_p & ~bus.tx_abort;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_state  <= S_IDLE;
      r_sr     <= '0;
      r_trl    <= 1'b0;
      r_bit    <= 1'b0;
      r_active <= 1'b0;
      r_bitcnt <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_sr     <= w_nxt_sr;
      r_trl    <= w_nxt_trl;
      r_bit    <= w_nxt_bit;
      r_active <= w_nxt_active;
      r_bitcnt <= w_nxt_bitcnt;
      r_done   <= w_nxt_done;
    end
  end

  // r_sr[0] is always the sync bit for the current position; after 63 shifts it holds sync[63] for the trailer
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_sr     = r_sr;
    w_nxt_trl    = r_trl;
    w_nxt_bit    = r_bit;
    w_nxt_active = r_active;
    w_nxt_bitcnt = r_bitcnt;
    w_nxt_done   = 1'b0;
    if (bus.tx_abort) begin
      w_nxt_state  = S_IDLE;
      w_nxt_bit    = 1'b0;
      w_nxt_active = 1'b0;
      w_nxt_bitcnt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.tx_st_p) begin
            w_nxt_state = S_ARMED;
            w_nxt_sr    = bus.tx_sync;
            w_nxt_trl   = bus.trailer_en;
          end
        end
        S_ARMED: begin
          if (bus.p_1us) begin
            w_nxt_state  = S_PRE;
            w_nxt_bit    = r_sr[0];
            w_nxt_bitcnt = '0;
            w_nxt_active = 1'b1;
          end
        end
        S_PRE: begin
          if (bus.p_1us) begin
            w_nxt_bitcnt = r_bitcnt + 7'd1;
            if (r_bitcnt == 7'd3) begin
              w_nxt_state = S_SYNC;
              w_nxt_bit   = r_sr[0];
            end else begin
              w_nxt_bit = ~r_bit;
            end
          end
        end
        S_SYNC: begin
          if (bus.p_1us) begin
            if (r_bitcnt == 7'd67) begin
              if (r_trl) begin
                w_nxt_state  = S_TRL;
                w_nxt_bit    = ~r_sr[0];
                w_nxt_bitcnt = 7'd68;
              end else begin
                w_nxt_state  = S_IDLE;
                w_nxt_bit    = 1'b0;
                w_nxt_active = 1'b0;
                w_nxt_bitcnt = '0;
                w_nxt_done   = 1'b1;
              end
            end else begin
              w_nxt_sr     = {1'b0, r_sr[63:1]};
              w_nxt_bit    = r_sr[1];
              w_nxt_bitcnt = r_bitcnt + 7'd1;
            end
          end
        end
        S_TRL: begin
          if (bus.p_1us) begin
            if (r_bitcnt == 7'd71) begin
              w_nxt_state  = S_IDLE;
              w_nxt_bit    = 1'b0;
              w_nxt_active = 1'b0;
              w_nxt_bitcnt = '0;
              w_nxt_done   = 1'b1;
            end else begin
              w_nxt_bit    = ~r_bit;
              w_nxt_bitcnt = r_bitcnt + 7'd1;
            end
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end
  end

  // Slot timer keeps running after the access code ends; only abort or reset stops it
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_slot_run <= 1'b0;
      r_slot_cnt <= '0;
    end else if (bus.tx_abort) begin
      r_slot_run <= 1'b0;
      r_slot_cnt <= '0;
    end else if (w_accept) begin
      r_slot_run <= 1'b1;
      r_slot_cnt <= '0;
    end else if (r_slot_run && bus.p_1us) begin
      r_slot_cnt <= (r_slot_cnt == SLOT_TC) ? 10'd0 : r_slot_cnt + 10'd1;
    end
  end

  assign bus.tx_bit               = r_bit;
  assign bus.tx_active            = r_active;
  assign bus.tx_bitcnt            = r_bitcnt;
  assign bus.tx_ac_done_p         = r_done;
  assign bus.tx_halftslotdly_endp = r_slot_run & bus.p_1us & (r_slot_cnt == HALF_TC);
  assign bus.tx_tslotdly_endp     = r_slot_run & bus.p_1us & (r_slot_cnt == SLOT_TC);

endmodule
